// File: rtl/cascaded_compare_accumulator_pkg.sv
// Shared definitions for the cascaded compare accumulator: FSM state encoding
// and the default slice count.
package cascaded_compare_accumulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_NUM_SLICES = 4;

endpackage

// File: rtl/cascaded_compare_accumulator.sv
// Folds serial 2-bit comparator results (MSB slice first) into one
// greater/equal/less verdict for a wide word, with done and err pulses.
module cascaded_compare_accumulator
    import cascaded_compare_accumulator_pkg::*;
#(
    parameter int NUM_SLICES = DEFAULT_NUM_SLICES,
    parameter int CW         = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic slice_valid,
    input  logic slice_gt,
    input  logic slice_eq,
    input  logic slice_last,
    output logic busy,
    output logic done,
    output logic A_gt,
    output logic A_eq,
    output logic A_lt,
    output logic err
);

    state_t        state;
    logic [CW-1:0] count;
    logic          decided;
    logic          run_gt;
    logic          run_eq;

    logic          fold_gt;
    logic          fold_eq;
    logic          fold_dec;
    logic          last_slot;

    // Running decision with the current slice folded in; only the first
    // non-equal slice can change it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        fold_gt  = run_gt;
        fold_eq  = run_eq;
        fold_dec = decided;
        if (!decided) begin
            if (slice_gt) begin
                fold_gt  = 1'b1;
                fold_eq  = 1'b0;
                fold_dec = 1'b1;
            end else if (!slice_eq) begin
                fold_gt  = 1'b0;
                fold_eq  = 1'b0;
                fold_dec = 1'b1;
            end
        end
    end

    assign last_slot = (count == CW'(NUM_SLICES - 1));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state   <= ST_IDLE;
            count   <= '0;
            decided <= 1'b0;
            run_gt  <= 1'b0;
            run_eq  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            A_gt    <= 1'b0;
            A_eq    <= 1'b0;
            A_lt    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            // start wins in every state, including over a slice in the same cycle.
            if (start) begin
                state   <= ST_ACCUM;
                busy    <= 1'b1;
                count   <= '0;
                decided <= 1'b0;
                run_gt  <= 1'b0;
                run_eq  <= 1'b1;
                A_gt    <= 1'b0;
                A_eq    <= 1'b0;
                A_lt    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        busy <= 1'b0;
                    end
                    ST_ACCUM: begin
                        if (slice_valid) begin
                            if (slice_gt && slice_eq) begin
                                err   <= 1'b1;
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                run_gt  <= fold_gt;
                                run_eq  <= fold_eq;
                                decided <= fold_dec;
                                count   <= count + CW'(1);
                                if (slice_last && last_slot) begin
                                    state <= ST_DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                    A_gt  <= fold_gt;
                                    A_eq  <= fold_eq;
                                    A_lt  <= ~(fold_gt | fold_eq);
                                end else if (slice_last || last_slot) begin
                                    // Early or missing last marker.
                                    err   <= 1'b1;
                                    state <= ST_IDLE;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
